// File: rtl/stack_arbiter_if.sv
// Client/engine-facing bundle of the stack arbiter: two requesters plus the stack engine command/status.
interface stack_arbiter_if #(
   parameter int unsigned DW = 8
);
   logic          req_a;
   logic          op_a;
   logic [DW-1:0] wdata_a;
   logic          ack_a;
   logic [DW-1:0] rdata_a;
   logic          err_a;

   logic          req_b;
   logic          op_b;
   logic [DW-1:0] wdata_b;
   logic          ack_b;
   logic [DW-1:0] rdata_b;
   logic          err_b;

   logic          stk_push;
   logic          stk_pop;
   logic [DW-1:0] stk_wdata;
   logic [DW-1:0] stk_rdata;
   logic          stk_done;
   logic          stk_empty;
   logic          stk_full;

   logic          busy;
   logic          timeout_flag;

   // Arbiter side
   modport slave (
      input  req_a, op_a, wdata_a, req_b, op_b, wdata_b,
      input  stk_rdata, stk_done, stk_empty, stk_full,
      output ack_a, rdata_a, err_a, ack_b, rdata_b, err_b,
      output stk_push, stk_pop, stk_wdata, busy, timeout_flag
   );

   // Requesters and stack engine side
   modport master (
      output req_a, op_a, wdata_a, req_b, op_b, wdata_b,
      output stk_rdata, stk_done, stk_empty, stk_full,
      input  ack_a, rdata_a, err_a, ack_b, rdata_b, err_b,
      input  stk_push, stk_pop, stk_wdata, busy, timeout_flag
   );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack engine between requesters A and B,
// with full/empty pre-check, single-cycle command pulses and a completion timeout.
module stack_arbiter #(
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input logic           clk,
   input logic           rst_n,
   stack_arbiter_if.slave bus
);
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        r_state,   w_state_nx;
   logic          r_gnt_b,   w_gnt_b_nx;
   logic          r_op,      w_op_nx;
   logic          r_rr_b,    w_rr_b_nx;
   logic [CW-1:0] r_cnt,     w_cnt_nx;
   logic          r_ack_a,   w_ack_a_nx;
   logic          r_ack_b,   w_ack_b_nx;
   logic          r_err_a,   w_err_a_nx;
   logic          r_err_b,   w_err_b_nx;
   logic          r_push,    w_push_nx;
   logic          r_pop,     w_pop_nx;
   logic          r_busy,    w_busy_nx;
   logic          r_tflag,   w_tflag_nx;
   logic [DW-1:0] r_rdata_a, w_rdata_a_nx;
   logic [DW-1:0] r_rdata_b, w_rdata_b_nx;
   logic [DW-1:0] r_wdata,   w_wdata_nx;

   // Winner selection: a lone requester wins, a tie goes to the rr pointer
   logic          w_sel_b;
   logic          w_sel_op;
   logic [DW-1:0] w_sel_wdata;
   logic          w_reject;

   assign w_sel_b     = bus.req_b & (~bus.req_a | r_rr_b);
   assign w_sel_op    = w_sel_b ? bus.op_b : bus.op_a;
   assign w_sel_wdata = w_sel_b ? bus.wdata_b : bus.wdata_a;
   assign w_reject    = w_sel_op ? bus.stk_full : bus.stk_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_gnt_b   <= 1'b0;
         r_op      <= 1'b0;
         r_rr_b    <= 1'b0;
         r_cnt     <= '0;
         r_ack_a   <= 1'b0;
         r_ack_b   <= 1'b0;
         r_err_a   <= 1'b0;
         r_err_b   <= 1'b0;
         r_push    <= 1'b0;
         r_pop     <= 1'b0;
         r_busy    <= 1'b0;
         r_tflag   <= 1'b0;
         r_rdata_a <= '0;
         r_rdata_b <= '0;
         r_wdata   <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_gnt_b   <= w_gnt_b_nx;
         r_op      <= w_op_nx;
         r_rr_b    <= w_rr_b_nx;
         r_cnt     <= w_cnt_nx;
         r_ack_a   <= w_ack_a_nx;
         r_ack_b   <= w_ack_b_nx;
         r_err_a   <= w_err_a_nx;
         r_err_b   <= w_err_b_nx;
         r_push    <= w_push_nx;
         r_pop     <= w_pop_nx;
         r_busy    <= w_busy_nx;
         r_tflag   <= w_tflag_nx;
         r_rdata_a <= w_rdata_a_nx;
         r_rdata_b <= w_rdata_b_nx;
         r_wdata   <= w_wdata_nx;
      end
   end

   // Next state and next values of every registered output
   always_comb begin
      w_state_nx   = r_state;
      w_gnt_b_nx   = r_gnt_b;
      w_op_nx      = r_op;
      w_rr_b_nx    = r_rr_b;
      w_cnt_nx     = r_cnt;
      w_ack_a_nx   = 1'b0;
      w_ack_b_nx   = 1'b0;
      w_err_a_nx   = 1'b0;
      w_err_b_nx   = 1'b0;
      w_push_nx    = 1'b0;
      w_pop_nx     = 1'b0;
      w_tflag_nx   = r_tflag;
      w_rdata_a_nx = r_rdata_a;
      w_rdata_b_nx = r_rdata_b;
      w_wdata_nx   = r_wdata;

      unique case (r_state)
         S_IDLE: begin
            if (bus.req_a | bus.req_b) begin
               w_gnt_b_nx = w_sel_b;
               w_op_nx    = w_sel_op;
               if (w_reject) begin
                  w_state_nx = S_RESP;
                  w_ack_a_nx = ~w_sel_b;
                  w_ack_b_nx = w_sel_b;
                  w_err_a_nx = ~w_sel_b;
                  w_err_b_nx = w_sel_b;
                  if (!w_sel_op) begin
                     if (w_sel_b) w_rdata_b_nx = '0;
                     else         w_rdata_a_nx = '0;
                  end
               end else begin
                  w_state_nx = S_ISSUE;
                  w_push_nx  = w_sel_op;
                  w_pop_nx   = ~w_sel_op;
                  w_cnt_nx   = '0;
                  if (w_sel_op) w_wdata_nx = w_sel_wdata;
               end
            end
         end
         // Engine completion during the command cycle is not honoured
         S_ISSUE: w_state_nx = S_WAIT;
         S_WAIT: begin
            if (bus.stk_done) begin
               w_state_nx = S_RESP;
               w_ack_a_nx = ~r_gnt_b;
               w_ack_b_nx = r_gnt_b;
               if (!r_op) begin
                  if (r_gnt_b) w_rdata_b_nx = bus.stk_rdata;
                  else         w_rdata_a_nx = bus.stk_rdata;
               end
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_state_nx = S_RESP;
               w_ack_a_nx = ~r_gnt_b;
               w_ack_b_nx = r_gnt_b;
               w_err_a_nx = ~r_gnt_b;
               w_err_b_nx = r_gnt_b;
               w_tflag_nx = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         S_RESP: begin
            w_state_nx = S_IDLE;
            w_rr_b_nx  = ~r_gnt_b;
         end
         default: w_state_nx = S_IDLE;
      endcase

      w_busy_nx = (w_state_nx != S_IDLE);
   end

   assign bus.ack_a        = r_ack_a;
   assign bus.ack_b        = r_ack_b;
   assign bus.err_a        = r_err_a;
   assign bus.err_b        = r_err_b;
   assign bus.rdata_a      = r_rdata_a;
   assign bus.rdata_b      = r_rdata_b;
   assign bus.stk_push     = r_push;
   assign bus.stk_pop      = r_pop;
   assign bus.stk_wdata    = r_wdata;
   assign bus.busy         = r_busy;
   assign bus.timeout_flag = r_tflag;
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: vector table of single transactions plus
// round-robin, input-stability and reset-abort sequences.
module tb_stack_arbiter;
   localparam int unsigned DW      = 8;
   localparam int unsigned TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stack_arbiter_if #(.DW(DW)) bus ();

   stack_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Engine model: stk_done eng_lat cycles after a command (0 = never), or on a manual kick
   int   eng_lat   = 0;
   int   kick_req  = 0;
   int   kick_seen = 0;
   logic pend      = 1'b0;
   int   cd        = 0;
   initial begin
      bus.stk_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.stk_done = 1'b0;
         if (kick_req != kick_seen) begin
            kick_seen    = kick_req;
            bus.stk_done = 1'b1;
         end
         if (pend) begin
            if (cd == 0) begin
               bus.stk_done = 1'b1;
               pend         = 1'b0;
            end else cd--;
         end
         if ((bus.stk_push || bus.stk_pop) && eng_lat > 0) begin
            pend = 1'b1;
            cd   = eng_lat - 1;
         end
      end
   end

   // Monitor: pulse counts, ack order, pushed data, exclusivity violations
   int            push_cnt = 0, pop_cnt = 0, ack_a_cnt = 0, ack_b_cnt = 0, ovl_cnt = 0;
   logic [DW-1:0] last_push_wdata = '0;
   int            ack_q[$];
   logic [DW-1:0] pushw_q[$];
   always @(negedge clk) begin
      if (bus.stk_push) begin
         push_cnt++;
         last_push_wdata = bus.stk_wdata;
         pushw_q.push_back(bus.stk_wdata);
      end
      if (bus.stk_pop) pop_cnt++;
      if (bus.ack_a) begin ack_a_cnt++; ack_q.push_back(0); end
      if (bus.ack_b) begin ack_b_cnt++; ack_q.push_back(1); end
      if (bus.ack_a && bus.ack_b) ovl_cnt++;
      if (bus.stk_push && bus.stk_pop) ovl_cnt++;
   end

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_a     = 1'b0; bus.op_a = 1'b0; bus.wdata_a = '0;
      bus.req_b     = 1'b0; bus.op_b = 1'b0; bus.wdata_b = '0;
      bus.stk_rdata = '0;   bus.stk_empty = 1'b0; bus.stk_full = 1'b0;
      eng_lat       = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // One transaction from an idle arbiter; n counts edges from the grant edge (n=1) to ack
   task automatic xact(input logic sel_b, input logic op, input logic [DW-1:0] wd,
                       input logic full, input logic empty, input int lat,
                       input logic [DW-1:0] rin, output int n, output logic err,
                       output logic [DW-1:0] rd, output logic got);
      eng_lat       = lat;
      bus.stk_rdata = rin;
      bus.stk_full  = full;
      bus.stk_empty = empty;
      if (sel_b) begin bus.req_b = 1'b1; bus.op_b = op; bus.wdata_b = wd; end
      else       begin bus.req_a = 1'b1; bus.op_a = op; bus.wdata_a = wd; end
      n = 0; got = 1'b0; err = 1'b0; rd = '0;
      while (!got && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (sel_b ? bus.ack_b : bus.ack_a) begin
            got = 1'b1;
            err = sel_b ? bus.err_b : bus.err_a;
            rd  = sel_b ? bus.rdata_b : bus.rdata_a;
         end
      end
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic          sel_b;
      logic          op;
      logic [DW-1:0] wdata;
      logic          full;
      logic          empty;
      int            lat;
      logic [DW-1:0] rin;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
      int            exp_n;
      int            exp_push;
      int            exp_pop;
      logic          exp_tflag;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int            n, p0, q0, base_a, base_w, bad, a0, b0, p1, q1;
      logic          err, got;
      logic [DW-1:0] rd;

      //          sel  op   wdata  full empty lat rin    err  rdata  n   push pop tflag
      vecs[0] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 8'h00, 1'b0, 8'h00, 3,  1, 0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h5A, 1'b0, 8'h5A, 3,  0, 1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 8'hAA, 1'b1, 8'h00, 1,  0, 0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1, 8'h00, 1'b1, 8'h00, 1,  0, 0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 3, 8'h00, 1'b0, 8'h00, 5,  1, 0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2, 8'hC3, 1'b0, 8'hC3, 4,  0, 1, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h5F, 1'b1, 8'hC3, 17, 0, 1, 1'b1};
      vecs[7] = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1, 8'h00, 1'b0, 8'h00, 3,  1, 0, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h99, 1'b0, 8'h99, 3,  0, 1, 1'b1};

      // Reset values
      do_reset();
      check("reset_outputs", int'({bus.ack_a, bus.ack_b, bus.err_a, bus.err_b, bus.stk_push,
                                   bus.stk_pop, bus.busy, bus.timeout_flag, bus.rdata_a,
                                   bus.rdata_b, bus.stk_wdata}), 0);
      release_reset();
      check("idle_busy", int'(bus.busy), 0);

      // Round-robin with both requesters held high
      eng_lat     = 1;
      base_a      = ack_q.size();
      base_w      = pushw_q.size();
      bus.op_a    = 1'b1; bus.wdata_a = 8'h11;
      bus.op_b    = 1'b1; bus.wdata_b = 8'h22;
      bus.req_a   = 1'b1; bus.req_b   = 1'b1;
      n = 0;
      while (ack_q.size() < base_a + 4 && n < 80) begin
         @(posedge clk); #1;
         n++;
      end
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      check("rr_ack_count", int'(ack_q.size() >= base_a + 4), 1);
      for (int k = 0; k < 4; k++) begin
         if (ack_q.size() > base_a + k)
            check($sformatf("rr_order%0d", k), ack_q[base_a + k], k % 2);
         if (pushw_q.size() > base_w + k)
            check($sformatf("rr_wdata%0d", k), int'(pushw_q[base_w + k]),
                  (k % 2 == 1) ? 32'h22 : 32'h11);
      end

      // Vector table
      do_reset();
      release_reset();
      for (int i = 0; i < 9; i++) begin
         p0 = push_cnt;
         q0 = pop_cnt;
         xact(vecs[i].sel_b, vecs[i].op, vecs[i].wdata, vecs[i].full, vecs[i].empty,
              vecs[i].lat, vecs[i].rin, n, err, rd, got);
         check($sformatf("v%0d_ack", i),   int'(got), 1);
         check($sformatf("v%0d_err", i),   int'(err), int'(vecs[i].exp_err));
         check($sformatf("v%0d_lat", i),   n, vecs[i].exp_n);
         check($sformatf("v%0d_rdata", i), int'(rd), int'(vecs[i].exp_rdata));
         check($sformatf("v%0d_push", i),  push_cnt - p0, vecs[i].exp_push);
         check($sformatf("v%0d_pop", i),   pop_cnt - q0, vecs[i].exp_pop);
         check($sformatf("v%0d_tflag", i), int'(bus.timeout_flag), int'(vecs[i].exp_tflag));
         if (vecs[i].exp_push == 1)
            check($sformatf("v%0d_wdata", i), int'(last_push_wdata), int'(vecs[i].wdata));
      end

      // Push data must stay latched while the requester changes its bus
      eng_lat = 6;
      bus.stk_full = 1'b0; bus.stk_empty = 1'b0;
      bus.req_a = 1'b1; bus.op_a = 1'b1; bus.wdata_a = 8'h33;
      n = 0; bad = 0; got = 1'b0;
      while (!got && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (n == 3) bus.wdata_a = 8'h44;
         if (bus.stk_wdata != 8'h33) bad++;
         if (bus.ack_a) got = 1'b1;
      end
      bus.req_a = 1'b0;
      check("stab_ack", int'(got), 1);
      check("stab_lat", n, 8);
      check("stab_wdata_bad_cycles", bad, 0);
      @(posedge clk); #1;

      // Reset in the middle of a WAIT aborts without ack; a late stk_done is ignored
      eng_lat = 0;
      a0 = ack_a_cnt;
      b0 = ack_b_cnt;
      bus.req_a = 1'b1; bus.op_a = 1'b1; bus.wdata_a = 8'h66;
      repeat (4) @(posedge clk);
      #1;
      check("midop_busy", int'(bus.busy), 1);
      rst_n = 1'b0;
      #2;
      check("midop_reset_outputs", int'({bus.ack_a, bus.ack_b, bus.err_a, bus.err_b,
                                         bus.stk_push, bus.stk_pop, bus.busy,
                                         bus.timeout_flag, bus.rdata_a, bus.rdata_b,
                                         bus.stk_wdata}), 0);
      bus.req_a = 1'b0;
      release_reset();
      p1 = push_cnt;
      q1 = pop_cnt;
      kick_req++;
      repeat (5) @(posedge clk);
      #1;
      check("late_done_ack", (ack_a_cnt - a0) + (ack_b_cnt - b0), 0);
      check("late_done_busy", int'(bus.busy), 0);
      check("late_done_cmds", (push_cnt - p1) + (pop_cnt - q1), 0);
      check("late_done_tflag", int'(bus.timeout_flag), 0);

      check("exclusive_pulses", ovl_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one 8-bit LIFO stack engine between two requesters (A, B).
- Arbitrates round-robin and sequences each push/pop into a single-cycle command pulse to the stack engine.
- Waits for the engine's completion, returns pop data and error status to the granted requester, and enforces a completion timeout.
- Sits between client logic and the stack engine in the tt06 stack design.

Parameters:
- DW, 8, data width of stack words.
- TIMEOUT, 15, max cycles waited for stk_done before aborting; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A request, held until ack_a
- op_a  in  1  A operation: 1=push, 0=pop; stable while req_a
- wdata_a  in  DW  A push data; stable while req_a
- ack_a  out  1  one-cycle completion pulse to A
- rdata_a  out  DW  A pop data; valid when ack_a=1, else holds last value
- err_a  out  1  valid with ack_a: 1 = overflow, underflow or timeout
- req_b, op_b, wdata_b, ack_b, rdata_b, err_b: same as A, for requester B
- stk_push  out  1  one-cycle push command to stack engine
- stk_pop  out  1  one-cycle pop command to stack engine
- stk_wdata  out  DW  push data to engine; held from issue until completion
- stk_rdata  in  DW  engine pop data; sampled when stk_done=1
- stk_done  in  1  engine completion pulse
- stk_empty  in  1  engine empty flag
- stk_full  in  1  engine full flag
- busy  out  1  high in any state other than IDLE
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer=A.
  - All outputs 0, including rdata_a, rdata_b, stk_wdata and timeout_flag.
  - Reset mid-operation aborts immediately with no ack.
  - An engine stk_done arriving after reset is ignored.
- States:
  - IDLE: arbitrate.
  - ISSUE: pulse stk_push or stk_pop for exactly one cycle.
  - WAIT: count cycles until stk_done.
  - RESP: pulse ack and err to the granted requester.
- Arbitration in IDLE:
  - Only one requester asserting: that requester wins.
  - Both asserting: the requester selected by rr wins. rr flips to the other requester after every RESP, whether the grant was serviced or errored.
  - Op, data and winner are latched at grant. Later input changes are ignored until RESP.
- Error pre-check at grant, using stk_full/stk_empty sampled in the IDLE cycle:
  - push with stk_full=1, or pop with stk_empty=1: go directly IDLE→RESP with err=1.
  - No stk_push/stk_pop pulse is issued.
  - Pop error returns rdata=0.
- Normal path: IDLE→ISSUE→WAIT→RESP→IDLE.
  - Minimum grant-to-ack latency is 3 cycles, which occurs when stk_done is seen in the first WAIT cycle.
  - stk_done while in ISSUE is ignored; the engine must respond at least 1 cycle after the command.
- WAIT timeout:
  - An 8-bit counter starts at 0 on entry to WAIT and increments each cycle without stk_done.
  - Counter reaching TIMEOUT: go to RESP with err=1 and set timeout_flag.
  - Timed-out pop leaves rdata unchanged.
- Data capture on stk_done with a pop: latch stk_rdata into the granted requester's rdata register.
- RESP lasts exactly 1 cycle, then IDLE.
  - The requester must drop req in the cycle after ack. If req is still high, it is treated as a new request.
  - Back-to-back grants are therefore at best every 4 cycles (non-error path).
- ack_a and ack_b are never high together. stk_push and stk_pop are never high together.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Push then pop, single requester:
  - Stimulus: reset; A pushes 0x5A (stk_done 1 cycle after stk_push, empty=0, full=0); then A pops with stk_rdata=0x5A.
  - Response: stk_push high 1 cycle with stk_wdata=0x5A; ack_a 3 cycles after grant, err_a=0; pop returns rdata_a=0x5A, err_a=0.
- Simultaneous requests, round-robin:
  - Stimulus: req_a and req_b both held high continuously, both pushes (A=0x11, B=0x22).
  - Response: grants alternate A, B, A, B. ack_a and ack_b never overlap.
- Underflow and overflow:
  - Stimulus: A pop with stk_empty=1; then B push with stk_full=1.
  - Response: each acked 1 cycle after grant with err=1; no stk_pop or stk_push pulse; rdata_a=0x00.
- Timeout:
  - Stimulus: TIMEOUT=15; B pops, stk_done never asserted.
  - Response: ack_b with err_b=1 after 15 WAIT cycles; timeout_flag=1 and stays set through later successful ops.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WAIT of an A push; release; then send a late stk_done.
  - Response: no ack_a; all outputs 0 and busy=0 after reset; the late stk_done causes no activity.
- Input stability:
  - Stimulus: change wdata_a from 0x33 to 0x44 during WAIT.
  - Response: stk_wdata stays 0x33 until ack_a.
